// File: rtl/soc_system_onchip_memory2_pkg.sv
// ============================================================================
// soc_system_onchip_memory2_pkg
// Shared constants and helpers for the dual-port on-chip RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package soc_system_onchip_memory2_pkg;

    // Helpers work on a fixed maximum width; callers zero-extend and truncate
    localparam int MAX_DATA_W       = 1024;
    localparam int MAX_BE_W         = MAX_DATA_W / 8;
    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 2;

    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic bit latency_ok(input int lat);
        return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
    endfunction

    function automatic logic [MAX_DATA_W-1:0] merge_be(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/soc_system_onchip_memory2_if.sv
// ============================================================================
// soc_system_onchip_memory2_if
// Avalon-MM slave port bundle (one instance per RAM port).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface soc_system_onchip_memory2_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 6
);
    import soc_system_onchip_memory2_pkg::*;

    localparam int BE_W = be_w(DATA_W);

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid
    );

endinterface

`default_nettype wire

// File: rtl/soc_system_onchip_memory2_rdpipe.sv
// ============================================================================
// soc_system_onchip_memory2_rdpipe
// Read-data/valid pipeline of depth READ_LATENCY; data holds when idle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module soc_system_onchip_memory2_rdpipe #(
    parameter int DATA_W       = 128,
    parameter int READ_LATENCY = 1
) (
    input  wire               clk,
    input  wire               reset,
    input  wire               in_valid,
    input  wire  [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q [READ_LATENCY];
    logic              valid_d [READ_LATENCY];
    logic [DATA_W-1:0] data_q  [READ_LATENCY];
    logic [DATA_W-1:0] data_d  [READ_LATENCY];

    // Each stage only loads on a valid beat so the output holds between reads
    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_valid ? in_data : data_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[READ_LATENCY-1];
    assign out_data  = data_q[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/soc_system_onchip_memory2_dp.sv
// ============================================================================
// soc_system_onchip_memory2_dp
// True dual-port RAM with collision merge, write-through bypass and counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module soc_system_onchip_memory2_dp
    import soc_system_onchip_memory2_pkg::*;
#(
    parameter int    DATA_W       = 128,
    parameter int    ADDR_W       = 6,
    parameter int    DEPTH        = 64,
    parameter int    READ_LATENCY = 1,
    parameter int    CNT_W        = 16,
    parameter string INIT_FILE    = "soc_system_onchip_memory2_1.hex"
) (
    input  wire                        clk,
    input  wire                        reset,
    soc_system_onchip_memory2_if.slave s1,
    soc_system_onchip_memory2_if.slave s2,
    output logic [CNT_W-1:0]           collision_count,
    input  wire                        collision_clear
);

    localparam int               BE_W    = be_w(DATA_W);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (!latency_ok(READ_LATENCY) || (DATA_W % 8 != 0) || (DATA_W > MAX_DATA_W)
        || (DEPTH > 2**ADDR_W)) begin : g_bad_params
        $error("soc_system_onchip_memory2_dp: illegal parameter combination");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_a, rd_a, wr_b, rd_b, in_a, in_b, same_wr, overlap;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b, rdata_a, rdata_b;
    logic [MAX_DATA_W-1:0] ext_old_b, ext_base_a, ext_wd_a, ext_wd_b;
    logic [MAX_DATA_W-1:0] merged_a, merged_b;
    logic [MAX_BE_W-1:0]   ext_be_a, ext_be_b;
    logic [CNT_W-1:0]      collision_count_q, collision_count_d;

    always_comb begin
        wr_a = s1.chipselect & s1.write;
        rd_a = s1.chipselect & s1.read & ~s1.write;
        wr_b = s2.chipselect & s2.write;
        rd_b = s2.chipselect & s2.read & ~s2.write;
        in_a = ({1'b0, s1.address} < DEPTH_L);
        in_b = ({1'b0, s2.address} < DEPTH_L);

        old_a = in_a ? mem[s1.address] : '0;
        old_b = in_b ? mem[s2.address] : '0;

        same_wr = wr_a & wr_b & in_a & (s1.address == s2.address);
        overlap = |(s1.byteenable & s2.byteenable);

        ext_old_b  = '0;
        ext_base_a = '0;
        ext_wd_a   = '0;
        ext_wd_b   = '0;
        ext_be_a   = '0;
        ext_be_b   = '0;
        ext_old_b[DATA_W-1:0] = old_b;
        ext_wd_a[DATA_W-1:0]  = s1.writedata;
        ext_wd_b[DATA_W-1:0]  = s2.writedata;
        ext_be_a[BE_W-1:0]    = s1.byteenable;
        ext_be_b[BE_W-1:0]    = s2.byteenable;

        // On a same-address collision port A's lanes are merged over port B's
        merged_b = merge_be(ext_old_b, ext_wd_b, ext_be_b);
        new_b    = merged_b[DATA_W-1:0];
        ext_base_a[DATA_W-1:0] = same_wr ? new_b : old_a;
        merged_a = merge_be(ext_base_a, ext_wd_a, ext_be_a);
        new_a    = merged_a[DATA_W-1:0];

        // Write-through bypass: a reader sees the word the other port is writing
        rdata_a = old_a;
        if (wr_b && in_b && (s2.address == s1.address)) begin
            rdata_a = new_b;
        end
        rdata_b = old_b;
        if (wr_a && in_a && (s1.address == s2.address)) begin
            rdata_b = new_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_a && in_a) begin
                mem[s1.address] <= new_a;
            end
            if (wr_b && in_b && !same_wr) begin
                mem[s2.address] <= new_b;
            end
        end
    end

    always_comb begin
        collision_count_d = collision_count_q;
        if (collision_clear) begin
            collision_count_d = '0;
        end else if (same_wr && overlap && (collision_count_q != CNT_MAX)) begin
            collision_count_d = collision_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_count_q <= '0;
        end else begin
            collision_count_q <= collision_count_d;
        end
    end

    assign collision_count = collision_count_q;

    soc_system_onchip_memory2_rdpipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_a),
        .in_data   (rdata_a),
        .out_valid (s1.readdatavalid),
        .out_data  (s1.readdata)
    );

    soc_system_onchip_memory2_rdpipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_b),
        .in_data   (rdata_b),
        .out_valid (s2.readdatavalid),
        .out_data  (s2.readdata)
    );

endmodule

`default_nettype wire
